control_unit: RTL

Multicycle RISC-V (RV32I subset) controller that drives the control inputs of `dataPath`. It is the decision-making end of the datapath control interface: it consumes the latched `instr` and the ALU flags, and produces every mux select, write enable and ALU operation. It sits beside `dataPath` in the CPU top level, with `MemWrite` going to the memory.

---
 rtl/control_pkg.sv | 26 ++
 rtl/alu_decoder.sv | 26 ++
 rtl/control_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared encodings, opcodes and FSM states for control_unit and dataPath.
package control_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_AUIPC
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
    ALU_SRA = 4'd9;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALURESULT = 2'd2;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_A = 2'd2, SRCA_ZERO = 2'd3;
  localparam logic [1:0] SRCB_REG = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  // cout is the no-borrow flag of A-B, so unsigned less-than is !cout
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic cout,
                                        input logic ovf, input logic sign);
    logic lt;
    lt = sign ^ ovf;
    return f3 == 3'b000 ? zero : f3 == 3'b001 ? !zero : f3 == 3'b100 ? lt :
           f3 == 3'b101 ? !lt : f3 == 3'b110 ? !cout : f3 == 3'b111 ? cout : 1'b0;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp class and funct fields to the ALU operation code.
module alu_decoder
  import control_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       op5_i,
  output logic [3:0] alu_control_o
);
  logic [3:0] funct_op;
  always_comb begin
    funct_op = ALU_ADD;
    case (funct3_i)
      3'b000: funct_op = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
      3'b001: funct_op = ALU_SLL;
      3'b010: funct_op = ALU_SLT;
      3'b011: funct_op = ALU_SLTU;
      3'b100: funct_op = ALU_XOR;
      3'b101: funct_op = funct7_5_i ? ALU_SRA : ALU_SRL;
      3'b110: funct_op = ALU_OR;
      3'b111: funct_op = ALU_AND;
    endcase
    alu_control_o = alu_op_i == ALUOP_SUB ? ALU_SUB : alu_op_i == ALUOP_FUNCT ? funct_op : ALU_ADD;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle RV32I Moore controller driving the dataPath selects and enables.
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        cout,
  input  logic        overflow,
  input  logic        sign,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        AdrSrc,
  output logic        PCWrite,
  output logic [2:0]  ImmSrc,
  output logic        MemWrite
);
  state_t state_q, state_d;
  alu_op_t alu_op;
  logic [6:0] op;
  logic [2:0] f3;
  logic unused_instr;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  alu_decoder u_alu_decoder (
    .alu_op_i     (alu_op),
    .funct3_i     (f3),
    .funct7_5_i   (instr[30]),
    .op5_i        (op[5]),
    .alu_control_o(ALUControl)
  );
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;
  // Outputs stay at their defaults throughout reset, whatever state the register holds
  always_comb begin
    state_d   = S_FETCH;
    alu_op    = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_REG;
    AdrSrc    = 1'b0;
    PCWrite   = 1'b0;
    ImmSrc    = IMM_I;
    MemWrite  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          IRWrite   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          PCWrite   = 1'b1;
          state_d   = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J : op == OP_STORE ? IMM_S :
                    (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
          state_d = (op == OP_LOAD || op == OP_STORE) ? S_MEMADR : op == OP_R ? S_EXECR :
                    op == OP_I ? S_EXECI : op == OP_BRANCH ? S_BRANCH : op == OP_JAL ? S_JAL :
                    op == OP_JALR ? S_JALR : op == OP_LUI ? S_LUI :
                    op == OP_AUIPC ? S_AUIPC : S_FETCH;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_A;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = op == OP_STORE ? IMM_S : IMM_I;
          state_d = op == OP_STORE ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          state_d = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_A;
          alu_op  = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_A;
          ALUSrcB = SRCB_IMM;
          alu_op  = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA = SRCA_A;
          alu_op  = ALUOP_SUB;
          PCWrite = branch_taken(f3, Zero, cout, overflow, sign);
        end
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          state_d = S_ALUWB;
        end
        S_JALR: begin
          ALUSrcA   = SRCA_A;
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALURESULT;
          PCWrite   = 1'b1;
          state_d   = S_LINK;
        end
        S_LINK: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          RegWrite  = 1'b1;
        end
        S_LUI: begin
          ALUSrcA = SRCA_ZERO;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
          state_d = S_ALUWB;
        end
        S_AUIPC: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
          state_d = S_ALUWB;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule
